// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// datapath widths and PC arithmetic helpers.
package instr_fetch_pkg;

    localparam int          INSTR_W       = 32;
    localparam logic [31:0] PC_INC        = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // One-hot encoding keeps the state decode to a single bit per state.
    typedef enum logic [2:0] {
        IF_BOOT = 3'b001,
        IF_REQ  = 3'b010,
        IF_HOLD = 3'b100
    } if_state_e;

    function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic               imem_req;
    logic [INSTR_W-1:0] imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/instr_fetch_timeout_cnt.sv
// Fetch timeout watchdog: counts consecutive un-acknowledged request cycles and
// pulses o_fetch_err for one cycle when TIMEOUT_CYCLES is reached, then restarts.
module instr_fetch_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_res_n,
    input  logic i_waiting,
    output logic o_fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (!i_waiting) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                r_cnt <= '0;
                r_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_fetch_err = r_err;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches from instruction memory and holds
// the word for the control FSM. Define IF_TIMEOUT_EN to add the fetch timeout/retry.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
`ifdef IF_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic               i_clk,
    input  logic               i_res_n,
    input  logic               i_instr_req,
    input  logic               i_branch,
    input  logic [INSTR_W-1:0] i_branch_target,
    instr_fetch_if.master      imem,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_pc
`ifdef IF_TIMEOUT_EN
    , output logic             o_fetch_err
`endif
);

    if_state_e          r_state, w_state_next;
    logic [INSTR_W-1:0] r_pc, w_pc_next;
    logic [INSTR_W-1:0] r_instr, w_instr_next;
    logic               r_instr_valid, w_instr_valid_next;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_state       <= IF_BOOT;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_instr       <= w_instr_next;
            r_instr_valid <= w_instr_valid_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a hold default first so no path infers a latch.
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_instr_next       = r_instr;
        w_instr_valid_next = r_instr_valid;
        case (r_state)
            IF_BOOT: w_state_next = IF_REQ;
            IF_REQ: begin
                if (imem.imem_ack) begin
                    w_instr_next       = imem.imem_rdata;
                    w_instr_valid_next = 1'b1;
                    w_state_next       = IF_HOLD;
                end
            end
            IF_HOLD: begin
                if (i_instr_req) begin
                    w_instr_valid_next = 1'b0;
                    w_pc_next          = i_branch ? align_pc(i_branch_target) : r_pc + PC_INC;
                    w_state_next       = IF_REQ;
                end
            end
            default: w_state_next = IF_BOOT;
        endcase
    end

    assign imem.imem_req  = (r_state == IF_REQ);
    assign imem.imem_addr = r_pc;
    assign o_instr        = r_instr;
    assign o_instr_valid  = r_instr_valid;
    assign o_pc           = r_pc;

`ifdef IF_TIMEOUT_EN
    logic w_waiting;
    assign w_waiting = imem.imem_req && !imem.imem_ack;

    instr_fetch_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .i_clk       (i_clk),
        .i_res_n     (i_res_n),
        .i_waiting   (w_waiting),
        .o_fetch_err (o_fetch_err)
    );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, reset-mid-fetch and
// timeout sequences, then random traffic against a transaction-level model.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        instr_req = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] o_instr, o_pc;
    logic        o_valid;
`ifdef IF_TIMEOUT_EN
    logic        o_err;
`endif

    instr_fetch_if bus ();

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC (RESET_PC)
`ifdef IF_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TIMEOUT)
`endif
    ) dut (
        .i_clk           (clk),
        .i_res_n         (res_n),
        .i_instr_req     (instr_req),
        .i_branch        (branch),
        .i_branch_target (target),
        .imem            (bus.master),
        .o_instr         (o_instr),
        .o_instr_valid   (o_valid),
        .o_pc            (o_pc)
`ifdef IF_TIMEOUT_EN
        , .o_fetch_err   (o_err)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        ir;
        logic        br;
        logic [31:0] tg;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic ir, input logic br, input logic [31:0] tg,
                                input logic ack, input logic [31:0] rd, input logic e_req,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic e_valid);
        return '{ir, br, tg, ack, rd, e_req, e_pc, e_instr, e_valid};
    endfunction

    // Transaction-level reference: a fetch is outstanding, or a word is held.
    bit          m_boot, m_req, m_valid, m_err;
    logic [31:0] m_pc, m_instr;
    int          m_wait;

    task automatic model_reset();
        m_boot = 1; m_req = 0; m_valid = 0; m_err = 0;
        m_pc = RESET_PC; m_instr = '0; m_wait = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".req"},   32'(bus.imem_req), 32'(m_req));
        check({tag, ".addr"},  bus.imem_addr, m_pc);
        check({tag, ".pc"},    o_pc, m_pc);
        check({tag, ".instr"}, o_instr, m_instr);
        check({tag, ".valid"}, 32'(o_valid), 32'(m_valid));
`ifdef IF_TIMEOUT_EN
        check({tag, ".err"},   32'(o_err), 32'(m_err));
`endif
    endtask

    // Called at a negedge: drive one cycle of inputs, advance model, compare.
    task automatic step(input string tag, input logic ir, input logic br, input logic [31:0] tg,
                        input logic ack, input logic [31:0] rd);
        bit n_err = 0;
        instr_req = ir; branch = br; target = tg;
        bus.imem_ack = ack; bus.imem_rdata = rd;
        if (m_boot) begin
            m_boot = 0; m_req = 1;
        end else if (m_req) begin
            if (ack) begin
                m_instr = rd; m_valid = 1; m_req = 0; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin n_err = 1; m_wait = 0; end
            end
        end else if (ir) begin
            m_valid = 0;
            m_pc = br ? {tg[31:2], 2'b00} : m_pc + 32'd4;
            m_req = 1;
        end
        m_err = n_err;
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int pulses;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;

        vecs[0]  = mk(0, 0, 32'h0,        1, 32'hFFFF_FFFF, 1, 32'h0,         32'h0,         0);
        vecs[1]  = mk(0, 0, 32'h0,        1, 32'h0000_0013, 0, 32'h0,         32'h13,        1);
        vecs[2]  = mk(1, 0, 32'h0,        0, 32'h0,         1, 32'h4,         32'h13,        0);
        vecs[3]  = mk(0, 0, 32'h0,        0, 32'h0,         1, 32'h4,         32'h13,        0);
        vecs[4]  = mk(0, 0, 32'h0,        1, 32'h0000_0093, 0, 32'h4,         32'h93,        1);
        vecs[5]  = mk(1, 1, 32'h103,      0, 32'h0,         1, 32'h100,       32'h93,        0);
        vecs[6]  = mk(0, 0, 32'h0,        1, 32'hAABB_CCDD, 0, 32'h100,       32'hAABB_CCDD, 1);
        vecs[7]  = mk(1, 1, 32'hFFFF_FFFF,0, 32'h0,         1, 32'hFFFF_FFFC, 32'hAABB_CCDD, 0);
        vecs[8]  = mk(0, 0, 32'h0,        1, 32'h1111_1111, 0, 32'hFFFF_FFFC, 32'h1111_1111, 1);
        vecs[9]  = mk(1, 0, 32'h0,        0, 32'h0,         1, 32'h0,         32'h1111_1111, 0);
        vecs[10] = mk(1, 1, 32'h500,      0, 32'h0,         1, 32'h0,         32'h1111_1111, 0);
        vecs[11] = mk(1, 1, 32'h500,      0, 32'h0,         1, 32'h0,         32'h1111_1111, 0);
        vecs[12] = mk(1, 1, 32'h500,      0, 32'h0,         1, 32'h0,         32'h1111_1111, 0);
        vecs[13] = mk(0, 0, 32'h0,        1, 32'h2222_2222, 0, 32'h0,         32'h2222_2222, 1);
        vecs[14] = mk(0, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 32'h0,         32'h2222_2222, 1);
        vecs[15] = mk(0, 1, 32'h40,       0, 32'h0,         0, 32'h0,         32'h2222_2222, 1);

        // Reset state, then BOOT cycle with outputs idle.
        repeat (2) @(negedge clk);
        check("rst.req",   32'(bus.imem_req), 32'h0);
        check("rst.pc",    o_pc, RESET_PC);
        check("rst.instr", o_instr, 32'h0);
        check("rst.valid", 32'(o_valid), 32'h0);
        res_n = 1'b1;
        check("boot.req",  32'(bus.imem_req), 32'h0);

        for (int i = 0; i < 16; i++) begin
            instr_req = vecs[i].ir; branch = vecs[i].br; target = vecs[i].tg;
            bus.imem_ack = vecs[i].ack; bus.imem_rdata = vecs[i].rd;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d.req", i),   32'(bus.imem_req), 32'(vecs[i].e_req));
            check($sformatf("vec%0d.addr", i),  bus.imem_addr, vecs[i].e_pc);
            check($sformatf("vec%0d.pc", i),    o_pc, vecs[i].e_pc);
            check($sformatf("vec%0d.instr", i), o_instr, vecs[i].e_instr);
            check($sformatf("vec%0d.valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
`ifdef IF_TIMEOUT_EN
            check($sformatf("vec%0d.err", i),   32'(o_err), 32'h0);
`endif
        end

        // Reset asserted mid-fetch with an ACK pending: immediate clear, late ACK ignored.
        instr_req = 1'b1; branch = 1'b0; bus.imem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        instr_req = 1'b0;
        check("midrst.pre_req",  32'(bus.imem_req), 32'h1);
        check("midrst.pre_addr", bus.imem_addr, 32'h4);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
        #2 res_n = 1'b0;
        #1;
        check("midrst.req",   32'(bus.imem_req), 32'h0);
        check("midrst.pc",    o_pc, RESET_PC);
        check("midrst.valid", 32'(o_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("midrst.late_instr", o_instr, 32'h0);
        check("midrst.late_valid", 32'(o_valid), 32'h0);
        bus.imem_ack = 1'b0;
        res_n = 1'b1;
        model_reset();
        check_all("postrst");
        step("refetch", 0, 0, 32'h0, 0, 32'h0);
        step("refetch_ack", 0, 0, 32'h0, 1, 32'h0000_0013);

        // Long stall: with the timeout enabled one FETCH_ERR pulse, same address retried.
        step("stall_go", 1, 1, 32'h0000_0803, 0, 32'h0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step($sformatf("stall%0d", i), 0, 0, 32'h0, 0, 32'h0);
`ifdef IF_TIMEOUT_EN
            if (o_err) pulses++;
`endif
        end
`ifdef IF_TIMEOUT_EN
        check("timeout.pulses", 32'(pulses), 32'd1);
`endif
        check("stall.addr", bus.imem_addr, 32'h0000_0800);
        step("stall_ack", 0, 0, 32'h0, 1, 32'h0000_0067);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tg;
            logic        ack;
            tg  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC - 32'($urandom_range(0, 3)) : $urandom;
            ack = ($urandom_range(0, 2) == 0);
            step($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 tg, ack, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
